regfile_read_stage: RTL

Parametrised, registered multi-port read stage for the register file: selects one of DEPTH WIDTH-bit register values per read port, applies write-bypass forwarding and the hardwired zero register, and captures the result in an output pipeline register with stall (hold) and flush control. Sits between the register array and the ID/EX boundary. It replaces per-port combinational 32:1 mux banks and removes the separate forwarding mux for the write-then-read-same-cycle case.

---
 rtl/regfile_read_stage.sv | 86 ++++++++
 1 files changed

// File: rtl/regfile_read_stage.sv
// Registered multi-port register-file read stage with write bypass,
// an optional hardwired zero register, and per-port stall/flush control.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   regout            current contents of all DEPTH registers
//   rd_sel, rd_en     per-port read index and capture enable (0 = hold)
//   flush             clears every port's output register and valid bit
//   wr_en/sel/data    same-cycle register-file write, forwarded to readers
//   rd_data, rd_valid registered read data and per-port valid flags
module regfile_read_stage #(
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 32,
  parameter int NPORTS  = 2,
  parameter bit ZERO_EN = 1'b1,
  parameter int SELW    = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DEPTH-1:0][WIDTH-1:0]    regout,
  input  logic [NPORTS-1:0][SELW-1:0]    rd_sel,
  input  logic [NPORTS-1:0]              rd_en,
  input  logic                           flush,
  input  logic                           wr_en,
  input  logic [SELW-1:0]                wr_sel,
  input  logic [WIDTH-1:0]               wr_data,
  output logic [NPORTS-1:0][WIDTH-1:0]   rd_data,
  output logic [NPORTS-1:0]              rd_valid
);

  // One extra bit so DEPTH itself is representable when it is a power of 2.
  localparam logic [SELW:0]   LIM  = (SELW+1)'(DEPTH);
  localparam logic [SELW-1:0] ZIDX = SELW'(DEPTH-1);

  logic [NPORTS-1:0][WIDTH-1:0] w_v;
  logic [NPORTS-1:0]            w_oor;
  logic [NPORTS-1:0]            w_zero;
  logic [NPORTS-1:0]            w_byp;

  logic [NPORTS-1:0][WIDTH-1:0] r_data;
  logic [NPORTS-1:0]            r_valid;

  // Out-of-range and zero-register selects win over bypass, so a write
  // to either can never leak into a reader.
  always_comb begin
    w_v    = '0;
    w_oor  = '0;
    w_zero = '0;
    w_byp  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      w_oor[p]  = ({1'b0, rd_sel[p]} >= LIM);
      w_zero[p] = ZERO_EN && (rd_sel[p] == ZIDX);
      w_byp[p]  = wr_en && (wr_sel == rd_sel[p]);
      if (w_oor[p]) begin
        w_v[p] = '0;
      end else if (w_zero[p]) begin
        w_v[p] = '0;
      end else if (w_byp[p]) begin
        w_v[p] = wr_data;
      end else begin
        w_v[p] = regout[rd_sel[p]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= '0;
    end else if (flush) begin
      r_data  <= '0;
      r_valid <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (rd_en[p]) begin
          r_data[p]  <= w_v[p];
          r_valid[p] <= 1'b1;
        end
      end
    end
  end

  assign rd_data  = r_data;
  assign rd_valid = r_valid;

endmodule
